// File: rtl/step_dir_pkg.sv
// Shared defaults and error-flag indices for the step/dir receive path.
// The err_idx_e values double as bit positions in a register-map error word.
package step_dir_pkg;

    localparam int DEF_POS_WIDTH    = 32;
    localparam int DEF_PERIOD_WIDTH = 24;
    localparam int DEF_MIN_HIGH     = 4;
    localparam int DEF_DIR_SETUP    = 2;

    localparam int NUM_ERR = 3;

    typedef enum logic [1:0] {
        ERR_SHORT     = 2'd0,
        ERR_DIR_SETUP = 2'd1,
        ERR_DISABLED  = 2'd2
    } err_idx_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_dir_decoder.sv
// Receive side of the step/dir/enable stepper interface: tracks commanded position
// and step period, and flags pulses that violate driver timing requirements.
module step_dir_decoder
    import step_dir_pkg::*;
#(
    parameter int POS_WIDTH    = DEF_POS_WIDTH,
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int DIR_SETUP    = DEF_DIR_SETUP
) (
    input  logic                    osc_clk,
    input  logic                    rst,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    enable_in,
    input  logic                    pos_load,
    input  logic [POS_WIDTH-1:0]    pos_load_value,
    input  logic                    err_clear,
    output logic [POS_WIDTH-1:0]    position,
    output logic                    step_strobe,
    output logic [PERIOD_WIDTH-1:0] step_period,
    output logic                    period_valid,
    output logic                    err_short,
    output logic                    err_dir_setup,
    output logic                    err_disabled
);

    localparam int HI_W = cnt_width(MIN_HIGH);
    localparam int DS_W = cnt_width(DIR_SETUP);
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;

    logic step_sync, dir_sync, en_sync;

    sync_2ff u_step_sync (.clk(osc_clk), .rst(rst), .d(step_in),   .q(step_sync));
    sync_2ff u_dir_sync  (.clk(osc_clk), .rst(rst), .d(dir_in),    .q(dir_sync));
    sync_2ff u_en_sync   (.clk(osc_clk), .rst(rst), .d(enable_in), .q(en_sync));

    logic                    step_dly;
    logic                    dir_dly;
    logic [1:0]              fill_cnt;
    logic                    hi_active;
    logic [HI_W-1:0]         hi_cnt;
    logic [DS_W-1:0]         dir_cnt;
    logic [PERIOD_WIDTH-1:0] per_cnt;
    logic                    per_seen;
    logic [NUM_ERR-1:0]      err_flags;

    logic               rise;
    logic               fall;
    logic               counted;
    logic               dir_change;
    logic [NUM_ERR-1:0] err_evt;

    // Edges only count once step_dly holds a real post-reset sample, so a step
    // already high when reset releases is ignored until it drops and rises again.
    always_comb begin
        rise       = (fill_cnt == 2'd3) && step_sync && !step_dly;
        fall       = hi_active && !step_sync;
        counted    = rise && en_sync;
        dir_change = (dir_sync != dir_dly);
        err_evt    = '0;
        err_evt[ERR_SHORT]     = fall && (hi_cnt < HI_W'(MIN_HIGH));
        err_evt[ERR_DIR_SETUP] = rise && (DIR_SETUP > 0) &&
                                 (dir_change || (dir_cnt < DS_W'(DIR_SETUP)));
        err_evt[ERR_DISABLED]  = rise && !en_sync;
    end

    always_ff @(posedge osc_clk or posedge rst) begin
        if (rst) begin
            step_dly     <= 1'b0;
            dir_dly      <= 1'b0;
            fill_cnt     <= 2'd0;
            hi_active    <= 1'b0;
            hi_cnt       <= '0;
            dir_cnt      <= '0;
            per_cnt      <= '0;
            per_seen     <= 1'b0;
            err_flags    <= '0;
            position     <= '0;
            step_strobe  <= 1'b0;
            step_period  <= '0;
            period_valid <= 1'b0;
        end else begin
            step_dly <= step_sync;
            dir_dly  <= dir_sync;
            if (fill_cnt != 2'd3)
                fill_cnt <= fill_cnt + 2'd1;

            // dir_cnt counts cycles dir has been stable, saturating at DIR_SETUP
            if (dir_change)
                dir_cnt <= DS_W'(1);
            else if (dir_cnt < DS_W'(DIR_SETUP))
                dir_cnt <= dir_cnt + DS_W'(1);

            if (rise) begin
                hi_active <= 1'b1;
                hi_cnt    <= HI_W'(1);
            end else if (fall) begin
                hi_active <= 1'b0;
            end else if (hi_active && (hi_cnt < HI_W'(MIN_HIGH))) begin
                hi_cnt <= hi_cnt + HI_W'(1);
            end

            // A saturated period counter means the measurement is stale
            if (per_cnt == PER_MAX)
                period_valid <= 1'b0;
            if (counted) begin
                per_cnt  <= PERIOD_WIDTH'(1);
                per_seen <= 1'b1;
                if (per_seen && (per_cnt != PER_MAX)) begin
                    step_period  <= per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + PERIOD_WIDTH'(1);
            end

            step_strobe <= counted;
            if (pos_load)
                position <= pos_load_value;
            else if (counted)
                position <= dir_sync ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);

            err_flags <= (err_flags & ~{NUM_ERR{err_clear}}) | err_evt;
        end
    end

    assign err_short     = err_flags[ERR_SHORT];
    assign err_dir_setup = err_flags[ERR_DIR_SETUP];
    assign err_disabled  = err_flags[ERR_DISABLED];

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: a scoreboard queue holds the expected position
// for every counted step and is drained as step_strobe pulses appear.
module tb_step_dir_decoder;

    logic        osc_clk;
    logic        rst;
    logic        step_in;
    logic        dir_in;
    logic        enable_in;
    logic        pos_load;
    logic [31:0] pos_load_value;
    logic        err_clear;
    logic [31:0] position;
    logic        step_strobe;
    logic [7:0]  step_period;
    logic        period_valid;
    logic        err_short;
    logic        err_dir_setup;
    logic        err_disabled;

    int          vectors = 0;
    int          miscompares = 0;
    int          strobe_count = 0;
    int          exp_strobes = 0;
    logic [31:0] exp_pos = '0;
    logic [31:0] exp_q[$];

    step_dir_decoder #(
        .POS_WIDTH   (32),
        .PERIOD_WIDTH(8),
        .MIN_HIGH    (4),
        .DIR_SETUP   (2)
    ) dut (
        .osc_clk       (osc_clk),
        .rst           (rst),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .enable_in     (enable_in),
        .pos_load      (pos_load),
        .pos_load_value(pos_load_value),
        .err_clear     (err_clear),
        .position      (position),
        .step_strobe   (step_strobe),
        .step_period   (step_period),
        .period_valid  (period_valid),
        .err_short     (err_short),
        .err_dir_setup (err_dir_setup),
        .err_disabled  (err_disabled)
    );

    initial begin
        osc_clk = 1'b0;
        forever #5 osc_clk = ~osc_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one step pulse; counted pulses push the position the DUT should report
    task automatic applyStimulus(input int high_cycles, input int low_cycles, input bit counted);
        if (counted) begin
            exp_pos = dir_in ? exp_pos + 32'd1 : exp_pos - 32'd1;
            exp_q.push_back(exp_pos);
            exp_strobes++;
        end
        step_in = 1'b1;
        repeat (high_cycles) @(negedge osc_clk);
        step_in = 1'b0;
        repeat (low_cycles) @(negedge osc_clk);
    endtask

    task automatic loadPosition(input logic [31:0] value);
        pos_load       = 1'b1;
        pos_load_value = value;
        @(negedge osc_clk);
        pos_load = 1'b0;
        exp_pos  = value;
        @(negedge osc_clk);
    endtask

    task automatic clearErrors();
        err_clear = 1'b1;
        @(negedge osc_clk);
        err_clear = 1'b0;
        @(negedge osc_clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pos"},    position, 32'd0);
        checkOutput({tag, "_strobe"}, {31'd0, step_strobe}, 32'd0);
        checkOutput({tag, "_period"}, {24'd0, step_period}, 32'd0);
        checkOutput({tag, "_valid"},  {31'd0, period_valid}, 32'd0);
        checkOutput({tag, "_errs"},   {29'd0, err_short, err_dir_setup, err_disabled}, 32'd0);
    endtask

    // Scoreboard side: each strobe must match the oldest outstanding expected position
    always @(negedge osc_clk) begin
        if (step_strobe) begin
            strobe_count++;
            vectors++;
            assert (exp_q.size() > 0)
            else begin
                miscompares++;
                $error("[TB] FAIL unexpected_strobe: observed=strobe pos=%0h expected=no strobe", position);
            end
            if (exp_q.size() > 0)
                checkOutput("strobe_pos", position, exp_q.pop_front());
        end
    end

    initial begin
        rst            = 1'b1;
        step_in        = 1'b0;
        dir_in         = 1'b1;
        enable_in      = 1'b1;
        pos_load       = 1'b0;
        pos_load_value = '0;
        err_clear      = 1'b0;
        repeat (3) @(negedge osc_clk);
        checkAllZero("reset");
        rst = 1'b0;
        repeat (8) @(negedge osc_clk);

        $display("[TB] up-count pulses");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5, 5, 1'b1);
            if (i == 0) begin
                checkOutput("first_valid", {31'd0, period_valid}, 32'd0);
            end else begin
                checkOutput("period_10", {24'd0, step_period}, 32'd10);
                checkOutput("valid_10",  {31'd0, period_valid}, 32'd1);
            end
        end
        checkOutput("pos_up",     position, 32'd10);
        checkOutput("strobes_up", strobe_count, exp_strobes);
        checkOutput("errs_up",    {29'd0, err_short, err_dir_setup, err_disabled}, 32'd0);

        $display("[TB] down-count and wrap");
        dir_in = 1'b0;
        repeat (8) @(negedge osc_clk);
        loadPosition(32'd0);
        checkOutput("load_zero", position, 32'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(5, 5, 1'b1);
        checkOutput("pos_down", position, 32'hFFFF_FFFD);
        dir_in = 1'b1;
        repeat (8) @(negedge osc_clk);
        loadPosition(32'h7FFF_FFFF);
        applyStimulus(5, 5, 1'b1);
        checkOutput("pos_wrap", position, 32'h8000_0000);

        $display("[TB] disabled steps");
        enable_in = 1'b0;
        repeat (8) @(negedge osc_clk);
        applyStimulus(5, 5, 1'b0);
        applyStimulus(5, 5, 1'b0);
        checkOutput("pos_disabled",     position, 32'h8000_0000);
        checkOutput("strobes_disabled", strobe_count, exp_strobes);
        checkOutput("err_disabled_set", {31'd0, err_disabled}, 32'd1);
        clearErrors();
        checkOutput("err_disabled_clr", {31'd0, err_disabled}, 32'd0);
        // err_clear lands on the same edge that registers the disabled rise
        step_in = 1'b1;
        @(negedge osc_clk);
        @(negedge osc_clk);
        err_clear = 1'b1;
        @(negedge osc_clk);
        err_clear = 1'b0;
        repeat (3) @(negedge osc_clk);
        step_in = 1'b0;
        repeat (5) @(negedge osc_clk);
        checkOutput("err_disabled_wins", {31'd0, err_disabled}, 32'd1);
        enable_in = 1'b1;
        repeat (8) @(negedge osc_clk);
        clearErrors();

        $display("[TB] short pulse and dir setup");
        applyStimulus(2, 6, 1'b1);
        checkOutput("err_short_set",   {31'd0, err_short}, 32'd1);
        checkOutput("err_dir_quiet",   {31'd0, err_dir_setup}, 32'd0);
        checkOutput("pos_short",       position, 32'h8000_0001);
        clearErrors();
        dir_in = 1'b0;
        @(negedge osc_clk);
        applyStimulus(5, 5, 1'b1);
        checkOutput("err_dir_set",     {31'd0, err_dir_setup}, 32'd1);
        checkOutput("err_short_quiet", {31'd0, err_short}, 32'd0);
        checkOutput("pos_new_dir",     position, 32'h8000_0000);

        $display("[TB] period stall");
        dir_in = 1'b1;
        repeat (8) @(negedge osc_clk);
        clearErrors();
        applyStimulus(5, 25, 1'b1);
        applyStimulus(5, 5, 1'b1);
        checkOutput("period_30", {24'd0, step_period}, 32'd30);
        checkOutput("valid_30",  {31'd0, period_valid}, 32'd1);
        repeat (290) @(negedge osc_clk);
        checkOutput("stall_valid",  {31'd0, period_valid}, 32'd0);
        checkOutput("stall_held",   {24'd0, step_period}, 32'd30);
        applyStimulus(5, 15, 1'b1);
        checkOutput("restart_valid", {31'd0, period_valid}, 32'd0);
        checkOutput("restart_held",  {24'd0, step_period}, 32'd30);
        applyStimulus(5, 15, 1'b1);
        checkOutput("period_20", {24'd0, step_period}, 32'd20);
        checkOutput("valid_20",  {31'd0, period_valid}, 32'd1);

        $display("[TB] reset mid-pulse");
        step_in = 1'b1;
        @(negedge osc_clk);
        @(negedge osc_clk);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        exp_pos = '0;
        @(negedge osc_clk);
        @(negedge osc_clk);
        rst = 1'b0;
        repeat (10) @(negedge osc_clk);
        checkOutput("held_pos",     position, 32'd0);
        checkOutput("held_strobes", strobe_count, exp_strobes);
        step_in = 1'b0;
        repeat (6) @(negedge osc_clk);
        checkOutput("held_no_short", {31'd0, err_short}, 32'd0);
        applyStimulus(5, 5, 1'b1);
        checkOutput("pos_after_reset", position, 32'd1);
        checkOutput("strobes_final",   strobe_count, exp_strobes);
        checkOutput("sb_drained",      exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receive end of the stepper step/dir/enable interface. The motion core drives that interface; this block consumes it.
- Used as an in-fabric loopback monitor and on the bench: it tracks the commanded position and the step period, and checks pulse timing against driver requirements.
- Inputs are asynchronous to osc_clk. The block synchronises them, then edge-detects, counts and checks.

Parameters:
POS_WIDTH, 32, width of signed position counter (two's complement)
PERIOD_WIDTH, 24, width of rising-edge-to-rising-edge period counter, unsigned
MIN_HIGH, 4, minimum step high time in osc_clk cycles
DIR_SETUP, 2, cycles dir must be stable before a step rising edge

Ports:
osc_clk  in  1  system clock
rst  in  1  asynchronous active-high reset
step_in  in  1  step pulse, asynchronous
dir_in  in  1  direction, asynchronous; 1 = count up, 0 = count down
enable_in  in  1  driver enable, asynchronous; 1 = enabled
pos_load  in  1  one-cycle strobe: load position from pos_load_value
pos_load_value  in  POS_WIDTH  value to load
err_clear  in  1  one-cycle strobe: clear sticky error flags
position  out  POS_WIDTH  signed accumulated position
step_strobe  out  1  one-cycle pulse for each counted step
step_period  out  PERIOD_WIDTH  cycles between the last two counted rising edges
period_valid  out  1  step_period holds a real measurement
err_short  out  1  sticky: step high time was below MIN_HIGH
err_dir_setup  out  1  sticky: dir changed within DIR_SETUP cycles before a rising edge
err_disabled  out  1  sticky: step rising edge seen while enable was low

Behaviour:
- Reset: rst is asynchronous and active-high. All outputs go to 0 and all internal counters and synchroniser flops clear. Reset mid-pulse discards any partial measurement.
- Synchronisation: each input passes through a 2-FF synchroniser. A third register on step gives the delayed copy for edge detection.
- A rising edge is synced step = 1 while its delayed copy = 0.
- Latency: from the first osc_clk edge that samples step_in high, position and step_strobe update on the 3rd edge.
- Counting: on a rising edge with synced enable = 1:
  - position += 1 if synced dir = 1, otherwise position -= 1;
  - step_strobe pulses for one cycle.
- Position wraps modulo 2^POS_WIDTH, with no saturation.
- Disabled step: a rising edge with synced enable = 0 is not counted and gives no strobe. It sets err_disabled.
- Dir setup: a counter tracks cycles since the last synced dir change; it saturates at DIR_SETUP. If the count is < DIR_SETUP at a rising edge, set err_dir_setup. The step is still counted, using the current synced dir.
- High-width check: a counter starts at 1 on the rising edge and increments while synced step stays high; it saturates at MIN_HIGH. If step falls with count < MIN_HIGH, set err_short. The step is not retracted.
- Period measurement: a counter increments every cycle and saturates at all-ones. On each counted rising edge:
  - if the counter has not saturated and a previous counted edge exists, step_period takes the counter value and period_valid = 1;
  - the counter then restarts at 1.
- Stall: if the counter saturates, period_valid drops to 0 and step_period is held at its last value. The first counted edge after a stall, or after reset, restarts the counter only and leaves period_valid = 0.
- Disabled edges do not affect period measurement.
- pos_load: position takes pos_load_value on the next edge. A load in the same cycle as a counted edge wins: the step delta is dropped, step_strobe is still asserted and the period update still happens.
- err_clear: clears all three sticky flags. An error event in the same cycle as err_clear wins, and that flag stays set.
- Back-to-back pulses: step high 1 cycle / low 1 cycle counts every pulse (one pulse per 2 cycles is the minimum resolvable). Each such pulse sets err_short when MIN_HIGH > 1.
- Glitches narrower than one osc_clk period may be missed. That is acceptable and not flagged.

Decomposition:
- Package step_dir_pkg holds:
  - default values for POS_WIDTH, PERIOD_WIDTH, MIN_HIGH and DIR_SETUP;
  - an error-flag index enum (ERR_SHORT, ERR_DIR_SETUP, ERR_DISABLED) for register-map reuse.
- One sub-module, sync_2ff: a single-bit two-flop synchroniser with asynchronous reset. It is instantiated three times (step, dir, enable).

Test Plan:
- Reset, then 10 up-pulses (high 5, low 5, dir=1, enable=1) → position = 10, 10 step_strobe pulses, step_period = 10 and period_valid = 1 from the 2nd pulse, no errors.
- dir=0 from position 0, 3 pulses → position = -3 (0xFFFFFFFD). Then pos_load 0x7FFFFFFF, one up-pulse → position = 0x80000000 (wrap).
- enable=0, 2 pulses → position unchanged, no strobe, err_disabled = 1. err_clear → 0. err_clear in the same cycle as a new disabled edge → stays 1.
- Pulse with high time 2 cycles (MIN_HIGH = 4) → counted, err_short = 1. Dir toggled 1 cycle before a rising edge → err_dir_setup = 1, step counted using the new dir.
- PERIOD_WIDTH = 8, gap of 300 cycles between pulses → period_valid drops when the counter saturates. The next pulse leaves period_valid = 0; the pulse after it (period 20) gives step_period = 20, period_valid = 1.
- Assert rst mid-pulse (step high 2 cycles) → all outputs 0 immediately. A step still high at release is not counted until it goes low and rises again, with no err_short.
